// File: rtl/booth_mult_arbiter_pkg.sv
// booth_arb_pkg: shared types and defaults for the multiplier arbiter.
package booth_arb_pkg;
    localparam int N_DEF       = 4;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic int cnt_w(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction
endpackage

// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: client request/response and multiplier-side signals.
interface booth_mult_arbiter_if #(
    parameter int N    = 4,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ*N-1:0]      req_multiplicand;
    logic [NREQ*N-1:0]      req_multiplier;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic signed [2*N-1:0]  rsp_product;
    logic                   rsp_err;
    logic                   busy;
    logic                   mult_start;
    logic signed [N-1:0]    mult_multiplicand;
    logic signed [N-1:0]    mult_multiplier;
    logic signed [2*N-1:0]  mult_product;
    logic                   mult_done;

    modport slave (
        input  req, req_multiplicand, req_multiplier, mult_product, mult_done,
        output gnt, rsp_valid, rsp_product, rsp_err, busy,
               mult_start, mult_multiplicand, mult_multiplier
    );

    modport master (
        output req, req_multiplicand, req_multiplier, mult_product, mult_done,
        input  gnt, rsp_valid, rsp_product, rsp_err, busy,
               mult_start, mult_multiplicand, mult_multiplier
    );
endinterface

// File: rtl/booth_mult_arbiter_rr_picker.sv
// rr_picker: first asserted request above the pointer, wrapping modulo NREQ.
module rr_picker #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx
);
    always_comb begin
        int j;
        logic found;
        j = 0;
        found = 1'b0;
        onehot = '0;
        idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                onehot[j] = 1'b1;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one multiplier among NREQ clients,
// with a watchdog that answers with an error if the multiplier never finishes.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                 clock,
    input logic                 reset,
    booth_mult_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_w(TIMEOUT);

    state_t          state;
    logic [IW-1:0]   ptr, owner, win_idx;
    logic [NREQ-1:0] win_oh;
    logic [CW-1:0]   cnt;

    rr_picker #(.NREQ(NREQ)) picker (.req(bus.req), .ptr(ptr), .onehot(win_oh), .idx(win_idx));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= IW'(NREQ - 1);
            owner <= '0;
            cnt <= '0;
            bus.gnt <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_product <= '0;
            bus.rsp_err <= 1'b0;
            bus.busy <= 1'b0;
            bus.mult_start <= 1'b0;
            bus.mult_multiplicand <= '0;
            bus.mult_multiplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a done still high here is stale (e.g. after a timeout); wait it out
                    if (|bus.req && !bus.mult_done) begin
                        owner <= win_idx;
                        ptr <= win_idx;
                        bus.mult_multiplicand <= bus.req_multiplicand[int'(win_idx)*N +: N];
                        bus.mult_multiplier <= bus.req_multiplier[int'(win_idx)*N +: N];
                        bus.gnt <= win_oh;
                        bus.mult_start <= 1'b1;
                        bus.busy <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.gnt <= '0;
                    bus.mult_start <= 1'b0;
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.mult_done || cnt == CW'(TIMEOUT - 1)) begin
                        bus.rsp_product <= bus.mult_done ? bus.mult_product : '0;
                        bus.rsp_err <= !bus.mult_done;
                        bus.rsp_valid <= NREQ'(1) << owner;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    bus.rsp_valid <= '0;
                    bus.rsp_err <= 1'b0;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: directed checks of the arbiter against a latency-configurable
// multiplier stub (N=4, NREQ=4, TIMEOUT=8).
module tb_booth_mult_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    booth_mult_arbiter_if #(.N(4), .NREQ(4)) bus ();

    booth_mult_arbiter #(.N(4), .NREQ(4), .TIMEOUT(8)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    // multiplier stub: done rises lat_cfg edges after start and stays high hold_cfg cycles
    logic stub_done;
    logic man_done = 1'b0;
    int   scnt, hcnt;
    int   lat_cfg = 3;
    int   hold_cfg = 1;
    bit   stuck = 1'b0;

    assign bus.mult_done = stub_done | man_done;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            stub_done <= 1'b0;
            scnt <= 0;
            hcnt <= 0;
            bus.mult_product <= '0;
        end else if (bus.mult_start && !stuck) begin
            scnt <= lat_cfg;
        end else if (scnt > 0) begin
            scnt <= scnt - 1;
            if (scnt == 1) begin
                stub_done <= 1'b1;
                hcnt <= hold_cfg - 1;
                bus.mult_product <= bus.mult_multiplicand * bus.mult_multiplier;
            end
        end else if (hcnt > 0) begin
            hcnt <= hcnt - 1;
        end else begin
            stub_done <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        bus.req_multiplicand[i*4 +: 4] = 4'(a);
        bus.req_multiplier[i*4 +: 4] = 4'(b);
    endtask

    // wait for grant of k, then for its response; lat counts cycles from grant to response
    task automatic serve(input int k, input int exp_p, input int exp_err, input bit drop, output int lat);
        int c;
        c = 0;
        while (bus.gnt == '0 && c < 30) begin
            @(negedge clock);
            c++;
        end
        chk("gnt_onehot", bus.gnt, 1 << k);
        chk("start_with_gnt", bus.mult_start, 1);
        chk("busy_at_issue", bus.busy, 1);
        if (drop) bus.req[k] = 1'b0;
        lat = 0;
        while (bus.rsp_valid == '0 && lat < 30) begin
            @(negedge clock);
            lat++;
        end
        chk("rsp_valid_owner", bus.rsp_valid, 1 << k);
        chk("rsp_product", bus.rsp_product, exp_p);
        chk("rsp_err", bus.rsp_err, exp_err);
    endtask

    int lat, extra, c;
    bit gseen, prev;
    int exp4[4] = '{-32, -7, 64, 0};

    initial begin
        bus.req = '0;
        bus.req_multiplicand = '0;
        bus.req_multiplier = '0;
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_start", bus.mult_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_product", bus.rsp_product, 0);
        chk("rst_mcand", bus.mult_multiplicand, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // single request: -5 * -3
        set_ops(0, -5, -3);
        bus.req = 4'b0001;
        @(negedge clock);
        chk("t1_gnt", bus.gnt, 1);
        chk("t1_start", bus.mult_start, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_mcand", bus.mult_multiplicand, -5);
        chk("t1_mplier", bus.mult_multiplier, -3);
        bus.req = '0;
        @(negedge clock);
        chk("t1_gnt_pulse", bus.gnt, 0);
        chk("t1_start_pulse", bus.mult_start, 0);
        c = 0;
        while (bus.rsp_valid == '0 && c < 30) begin
            @(negedge clock);
            c++;
        end
        chk("t1_latency", c, 4);
        chk("t1_rsp_valid", bus.rsp_valid, 1);
        chk("t1_product", bus.rsp_product, 15);
        chk("t1_err", bus.rsp_err, 0);
        @(negedge clock);
        chk("t1_rsp_pulse", bus.rsp_valid, 0);
        chk("t1_product_hold", bus.rsp_product, 15);
        chk("t1_busy_clear", bus.busy, 0);

        // reset so the pointer restarts; all four requesters at once -> 0,1,2,3
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        set_ops(0, -8, 4);
        set_ops(1, 7, -1);
        set_ops(2, -8, -8);
        set_ops(3, 0, -8);
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) serve(k, exp4[k], 0, 1'b1, lat);

        // req1 held, req2 pulsed: grants 1,2,1; then req3/req0 wrap the pointer
        @(negedge clock);
        set_ops(1, 2, 3);
        set_ops(2, -1, -1);
        set_ops(3, 3, -2);
        set_ops(0, 1, -8);
        bus.req = 4'b0110;
        serve(1, 6, 0, 1'b0, lat);
        serve(2, 1, 0, 1'b1, lat);
        serve(1, 6, 0, 1'b1, lat);
        @(negedge clock);
        bus.req = 4'b1001;
        serve(3, -6, 0, 1'b1, lat);
        serve(0, -8, 0, 1'b1, lat);

        // watchdog: done never comes
        @(negedge clock);
        stuck = 1'b1;
        set_ops(0, 2, 2);
        bus.req = 4'b0001;
        serve(0, 0, 1, 1'b1, lat);
        chk("t4_timeout_latency", lat, 9);
        // late done while idle must block the pending request
        man_done = 1'b1;
        bus.req = 4'b0001;
        repeat (4) @(negedge clock);
        chk("t4_blocked_busy", bus.busy, 0);
        chk("t4_blocked_gnt", bus.gnt, 0);
        man_done = 1'b0;
        stuck = 1'b0;
        serve(0, 4, 0, 1'b1, lat);

        // done held 5 cycles: one response only, next issue after done drops
        @(negedge clock);
        lat_cfg = 2;
        hold_cfg = 5;
        set_ops(1, -2, 5);
        set_ops(2, 3, 3);
        bus.req = 4'b0110;
        serve(1, -10, 0, 1'b1, lat);
        extra = 0;
        gseen = 1'b0;
        prev = bus.mult_done;
        c = 0;
        while (!gseen && c < 20) begin
            @(negedge clock);
            c++;
            if (bus.rsp_valid != '0) extra++;
            if (bus.gnt != '0) begin
                gseen = 1'b1;
                chk("t5_issue_after_done_low", prev, 0);
                chk("t5_second_gnt", bus.gnt, 4);
                bus.req[2] = 1'b0;
            end
            prev = bus.mult_done;
        end
        chk("t5_gnt_seen", gseen, 1);
        chk("t5_single_rsp", extra, 0);
        c = 0;
        while (bus.rsp_valid == '0 && c < 30) begin
            @(negedge clock);
            c++;
        end
        chk("t5_rsp2_valid", bus.rsp_valid, 4);
        chk("t5_rsp2_product", bus.rsp_product, 9);
        repeat (6) @(negedge clock);

        // reset during WAIT drops the operation; pending req0 served after release
        lat_cfg = 3;
        hold_cfg = 1;
        stuck = 1'b1;
        set_ops(0, -8, 7);
        bus.req = 4'b0001;
        @(negedge clock);
        chk("t6_gnt", bus.gnt, 1);
        repeat (3) @(negedge clock);
        chk("t6_busy_wait", bus.busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_async_busy", bus.busy, 0);
        chk("t6_async_product", bus.rsp_product, 0);
        chk("t6_async_mcand", bus.mult_multiplicand, 0);
        chk("t6_async_mplier", bus.mult_multiplier, 0);
        chk("t6_async_start", bus.mult_start, 0);
        chk("t6_async_gnt", bus.gnt, 0);
        repeat (2) @(negedge clock);
        chk("t6_no_rsp", bus.rsp_valid, 0);
        stuck = 1'b0;
        reset = 1'b1;
        serve(0, -56, 0, 1'b1, lat);
        chk("t6_latency", lat, 5);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
